// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Decode drives op with the same OP_* encodings.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULL = 2'b01,
        OP_SMULL = 2'b10,
        OP_UDIV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between mainfsm/decode (master) and the muldiv sequencer (slave).
interface muldiv_seq_if #(
    parameter int WIDTH = muldiv_pkg::WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result_lo, result_hi, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/muldiv_dp.sv
// Operand, accumulator and result registers with the radix-2 shift-add / restoring
// shift-subtract step, sequenced by load/prep/step/fix strobes from muldiv_seq.
module muldiv_dp
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             prep,
    input  logic             step,
    input  logic             fix,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             zero_div,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    op_e                op_q;
    logic [WIDTH-1:0]   opa, opb, acc_hi, acc_lo;
    logic               neg;
    logic               is_mul, is_smull, rem_ge;
    logic [WIDTH-1:0]   a_mag, b_mag, rem_diff;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [2*WIDTH-1:0] prod;

    assign is_mul   = (op_q != OP_UDIV);
    assign is_smull = (op_q == OP_SMULL);
    assign zero_div = (op_q == OP_UDIV) && (opb == '0);

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
    assign a_mag = (is_smull && opa[WIDTH-1]) ? -opa : opa;
    assign b_mag = (is_smull && opb[WIDTH-1]) ? -opb : opb;

    assign mul_sum  = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opa}) : {1'b0, acc_hi};
    assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, opb});
    assign rem_diff = rem_sh[WIDTH-1:0] - opb;
    assign prod     = (is_smull && neg) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= OP_MUL;
            opa         <= '0;
            opb         <= '0;
            neg         <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                op_q        <= op_e'(op_in);
                opa         <= a_in;
                opb         <= b_in;
                div_by_zero <= 1'b0;
            end
            if (prep) begin
                opa    <= a_mag;
                opb    <= b_mag;
                neg    <= is_smull && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                acc_hi <= '0;
                acc_lo <= is_mul ? b_mag : opa;
                if (zero_div) begin
                    result_lo   <= '1;
                    result_hi   <= opa;
                    div_by_zero <= 1'b1;
                end
            end
            // Multiply: acc_lo holds the shrinking multiplier; divide: acc_lo holds the growing quotient.
            if (step) begin
                if (is_mul) begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end else begin
                    acc_hi <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
                end
            end
            if (fix) begin
                if (is_mul) begin
                    result_hi <= prod[2*WIDTH-1:WIDTH];
                    result_lo <= prod[WIDTH-1:0];
                end else begin
                    result_hi <= acc_hi;
                    result_lo <= acc_lo;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MUL/UMULL/SMULL/UDIV sequencer; holds busy through PREP/RUN/FIX so
// mainfsm waits in execute, and pulses done for one cycle when results are loaded.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::WIDTH,
    parameter int CNT_W = muldiv_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);

    state_e           state;
    logic [CNT_W-1:0] count;
    logic             accept, zero_div;
    logic             prep, step, fix;

    // Flush wins over everything, including a start in the same cycle.
    assign accept = bus.start && !bus.flush && (state == S_IDLE || state == S_DONE);
    assign prep   = (state == S_PREP) && !bus.flush;
    assign step   = (state == S_RUN)  && !bus.flush;
    assign fix    = (state == S_FIX)  && !bus.flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            count    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.flush) begin
                state    <= S_IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            state    <= S_PREP;
                            bus.busy <= 1'b1;
                        end
                    end
                    S_PREP: begin
                        count <= '0;
                        if (zero_div) begin
                            state    <= S_DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                    S_DONE: begin
                        if (bus.start) begin
                            state    <= S_PREP;
                            bus.busy <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    muldiv_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .reset       (reset),
        .load        (accept),
        .prep        (prep),
        .step        (step),
        .fix         (fix),
        .op_in       (bus.op),
        .a_in        (bus.a),
        .b_in        (bus.b),
        .zero_div    (zero_div),
        .result_lo   (bus.result_lo),
        .result_hi   (bus.result_hi),
        .div_by_zero (bus.div_by_zero)
    );

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the multicycle core.
- Executes MUL, UMULL, SMULL and UDIV with a shared radix-2 shift-add/shift-subtract datapath.
- Raises busy so mainfsm holds in its execute state until done. Sits beside the ALU; decode selects the op, mainfsm issues start.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH, divide yields WIDTH quotient and WIDTH remainder.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  request pulse from mainfsm; sampled only in IDLE or DONE
- op  in  2  00 MUL, 01 UMULL, 10 SMULL, 11 UDIV; sampled with start
- a  in  WIDTH  Rn (multiplicand / dividend)
- b  in  WIDTH  Rm (multiplier / divisor)
- flush  in  1  synchronous abort; returns to IDLE, no done
- busy  out  1  high in PREP, RUN, FIX
- done  out  1  one-cycle pulse in DONE
- result_lo  out  WIDTH  MUL/UMULL/SMULL low word; UDIV quotient
- result_hi  out  WIDTH  UMULL/SMULL high word; MUL unsigned high word; UDIV remainder
- div_by_zero  out  1  UDIV with b==0; valid with done, held until next accepted start

Behaviour:
- Reset (reset=0): state IDLE, counter 0, busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: on start=1, latch op, a, b; go to PREP.
- PREP, 1 cycle:
  - SMULL: store |a|, |b| and neg = a[31]^b[31].
  - Others: operands pass unchanged.
  - Clear accumulator; counter=0.
  - UDIV with b==0: go to DONE, set div_by_zero=1, result_lo=all-ones, result_hi=a.
  - Otherwise go to RUN.
- RUN, exactly WIDTH cycles; each cycle counter+1.
  - Multiply: if multiplier LSB is 1, add the multiplicand into the upper half with carry out kept; then shift the {carry, acc_hi, acc_lo} register right 1.
  - UDIV, restoring: shift {rem, quo} left 1; if rem >= b, subtract b and set quo LSB.
  - Leave RUN when counter==WIDTH-1.
- FIX, 1 cycle: for SMULL with neg=1, two's-complement negate the 2*WIDTH product. Then load result_lo/result_hi and go to DONE.
- DONE, 1 cycle: done=1.
  - start=1 in the same cycle: accepted, go to PREP (back-to-back issue).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E, done high in the cycle after edge E+WIDTH+2 (35 cycles for WIDTH=32). Divide-by-zero gives done after E+1.
- Results hold their value from DONE until the FIX of the next op (or PREP for divide-by-zero).
- start while busy=1: ignored, no queuing.
- flush=1: in any state go to IDLE next edge; done suppressed; results keep previous values. flush beats start in the same cycle.
- Asynchronous reset mid-operation: immediate return to reset values; no partial result is visible.
- SMULL edge case: 0x80000000 magnitude is 2^31 unsigned; the |x| path is WIDTH bits unsigned, so no overflow.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MUL, OP_UMULL, OP_SMULL, OP_UDIV
  - state encoding S_IDLE..S_DONE
  - WIDTH default
- The same op encodings are used by decode when driving op.
- One sub-module, muldiv_dp: operand/accumulator registers and per-iteration add/subtract/shift, driven by the load/step/fix strobes from the FSM in muldiv_seq.

Test Plan:
- UMULL a=0xFFFFFFFF b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001; done exactly 35 cycles after start; busy high for 34 cycles.
- SMULL a=0xFFFFFFFE (-2) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. SMULL a=b=0x80000000 -> hi=0x40000000, lo=0.
- UDIV a=100 b=7 -> lo=14, hi=2, div_by_zero=0. UDIV a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1, done 2 cycles after start.
- Re-pulse start while busy with op=UDIV -> ignored; original UMULL result and timing unchanged. Start during DONE cycle -> second op's done 35 cycles later.
- flush at RUN cycle 10 -> IDLE next edge, no done, results keep previous values. Reset low at RUN cycle 20 -> all outputs 0 immediately.
- MUL a=0x00010000 b=0x00010000 -> lo=0, hi=1.
